reset_sequencer: RTL and testbench

//  Parametrised power-on/PLL reset generator; successor to the single-output power-on reset.

---
 rtl/reset_seq_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/reset_sequencer.sv | 169 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the staggered reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SW_HOLD   = 3'd4
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_LOCK_FILTER = 16;
    localparam int DEF_STAGE_DELAY = 8;
    localparam int DEF_HOLD_CYCLES = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter must hold the largest terminal value, including HOLD_CYCLES itself.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Filters PLL lock and releases NUM_CH active-low reset domains in index order;
// re-asserts all of them on lock loss or a software reset request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int LOCK_FILTER = DEF_LOCK_FILTER,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              pll_locked,
    input  logic              sw_rst_req,
    input  logic              lost_clr,
    output logic [NUM_CH-1:0] ch_res_n,
    output logic              seq_done,
    output logic              lock_lost,
    output state_e            dbg_state
);

    localparam int CW = cnt_width(LOCK_FILTER, STAGE_DELAY, HOLD_CYCLES);
    localparam int IW = clog2(NUM_CH + 1);

    localparam logic [CW-1:0]     LF_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0]     SD_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]     HOLD_END = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_FIRST = NUM_CH'(1);

    logic lk;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic              done_q, done_d;
    logic              lost_q, lost_d;
    logic              lose;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (res_n),
        .d_i   (pll_locked),
        .q_o   (lk)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    // Lock loss only counts once release has begun; losing it while filtering just restarts.
    assign lose = !lk && (state_q == RELEASE || state_q == RUN || state_q == SW_HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        done_d  = done_q;
        lost_d  = lost_q;

        if (lost_clr) lost_d = 1'b0;

        if (lose) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            ch_d    = '0;
            done_d  = 1'b0;
            lost_d  = 1'b1;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    cnt_d  = '0;
                    idx_d  = '0;
                    ch_d   = '0;
                    done_d = 1'b0;
                    if (lk) state_d = FILTER;
                end
                FILTER: begin
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == LF_LAST) begin
                        ch_d  = CH_FIRST;
                        idx_d = IDX_ONE;
                        cnt_d = '0;
                        if (NUM_CH == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == SD_LAST) begin
                        ch_d  = ch_q | (CH_FIRST << idx_q);
                        idx_d = idx_q + IDX_ONE;
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        state_d = SW_HOLD;
                        cnt_d   = '0;
                        idx_d   = '0;
                        ch_d    = '0;
                        done_d  = 1'b0;
                    end
                end
                SW_HOLD: begin
                    // Lock is still good here, so the filter is skipped on the way back.
                    if (cnt_q == HOLD_END) begin
                        ch_d  = CH_FIRST;
                        idx_d = IDX_ONE;
                        cnt_d = '0;
                        if (NUM_CH == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    ch_d    = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign ch_res_n  = ch_q;
    assign seq_done  = done_q;
    assign lock_lost = lost_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Table-driven bench for reset_sequencer: default instance plus a NUM_CH=1, STAGE_DELAY=1 instance.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       lost_clr;
    logic [3:0] ch_res_n;
    logic       seq_done;
    logic       lock_lost;
    state_e     dbg_state;

    logic [0:0] ch1_res_n;
    logic       done1;
    logic       lost1;
    state_e     dbg1;

    reset_sequencer #(
        .NUM_CH(4), .LOCK_FILTER(16), .STAGE_DELAY(8), .HOLD_CYCLES(4)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .pll_locked (pll_locked),
        .sw_rst_req (sw_rst_req),
        .lost_clr   (lost_clr),
        .ch_res_n   (ch_res_n),
        .seq_done   (seq_done),
        .lock_lost  (lock_lost),
        .dbg_state  (dbg_state)
    );

    reset_sequencer #(
        .NUM_CH(1), .LOCK_FILTER(16), .STAGE_DELAY(1), .HOLD_CYCLES(4)
    ) dut1 (
        .clk        (clk),
        .res_n      (res_n),
        .pll_locked (pll_locked),
        .sw_rst_req (1'b0),
        .lost_clr   (1'b0),
        .ch_res_n   (ch1_res_n),
        .seq_done   (done1),
        .lock_lost  (lost1),
        .dbg_state  (dbg1)
    );

    // One row: inputs driven before edge edge_n, outputs expected just after it.
    typedef struct {
        int         edge_n;
        logic       pll;
        logic       sw;
        logic       clr;
        logic [5:0] exp;
        bit         chk1;
        logic [5:0] exp1;
    } vec_t;

    vec_t       vec_q[$];
    logic [5:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ch=%b done=%b lost=%b, want ch=%b done=%b lost=%b",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input int e, input logic p, input logic s, input logic c,
                       input logic [3:0] ch, input logic d, input logic l,
                       input bit k1 = 1'b0, input logic c1 = 1'b0, input logic d1 = 1'b0);
        vec_t v;
        v.edge_n = e;
        v.pll    = p;
        v.sw     = s;
        v.clr    = c;
        v.exp    = {ch, d, l};
        v.chk1   = k1;
        v.exp1   = {3'b000, c1, d1, 1'b0};
        vec_q.push_back(v);
    endtask

    task automatic run_table(input string name, input int last_edge);
        for (int e = 0; e <= last_edge; e++) begin
            vec_t v;
            bit   hit;
            hit = (vec_q.size() > 0) && (vec_q[0].edge_n == e);
            if (hit) begin
                v          = vec_q.pop_front();
                pll_locked = v.pll;
                sw_rst_req = v.sw;
                lost_clr   = v.clr;
                exp_q.push_back(v.exp);
            end
            tick();
            if (hit) begin
                check($sformatf("%s@%0d", name, e), {ch_res_n, seq_done, lock_lost}, exp_q.pop_front());
                if (v.chk1)
                    check($sformatf("%s_n1@%0d", name, e), {3'b000, ch1_res_n, done1, lost1}, v.exp1);
            end
        end
        if (vec_q.size() != 0) begin
            failures++;
            $display("FAIL %s_table: %0d rows left unapplied, want 0", name, vec_q.size());
            vec_q.delete();
        end
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        lost_clr   = 1'b0;
        res_n      = 1'b1;
        #1;
        res_n = 1'b0;
        tick();
        tick();
        check("reset_out", {ch_res_n, seq_done, lock_lost}, 6'b0);
        check("reset_state", 6'(dbg_state), 6'(WAIT_LOCK));
        check("reset_out_n1", {3'b000, ch1_res_n, done1, lost1}, 6'b0);
        res_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        // Power-on release; the NUM_CH=1 instance finishes together with ch0.
        do_reset();
        add(0,  1, 0, 0, 4'b0000, 0, 0);
        add(17, 1, 0, 0, 4'b0000, 0, 0, 1, 0, 0);
        add(18, 1, 0, 0, 4'b0001, 0, 0, 1, 1, 1);
        add(25, 1, 0, 0, 4'b0001, 0, 0);
        add(26, 1, 0, 0, 4'b0011, 0, 0);
        add(33, 1, 0, 0, 4'b0011, 0, 0);
        add(34, 1, 0, 0, 4'b0111, 0, 0);
        add(41, 1, 0, 0, 4'b0111, 0, 0);
        add(42, 1, 0, 0, 4'b1111, 1, 0);
        run_table("release", 42);

        // Software reset pulse sampled in RUN at relative edge 0.
        add(0,  1, 1, 0, 4'b0000, 0, 0);
        add(1,  1, 0, 0, 4'b0000, 0, 0);
        add(4,  1, 0, 0, 4'b0000, 0, 0);
        add(5,  1, 0, 0, 4'b0001, 0, 0);
        add(12, 1, 0, 0, 4'b0001, 0, 0);
        add(13, 1, 0, 0, 4'b0011, 0, 0);
        add(28, 1, 0, 0, 4'b0111, 0, 0);
        add(29, 1, 0, 0, 4'b1111, 1, 0);
        run_table("sw_rst", 29);

        // One-cycle lock glitch restarts the filter without flagging lock loss.
        do_reset();
        add(0,  1, 0, 0, 4'b0000, 0, 0);
        add(10, 0, 0, 0, 4'b0000, 0, 0);
        add(11, 1, 0, 0, 4'b0000, 0, 0);
        add(18, 1, 0, 0, 4'b0000, 0, 0);
        add(28, 1, 0, 0, 4'b0000, 0, 0);
        add(29, 1, 0, 0, 4'b0001, 0, 0);
        run_table("glitch", 29);

        // Lock drops after ch1; then lost_clr; then the full filter runs again.
        do_reset();
        add(0,  1, 0, 0, 4'b0000, 0, 0);
        add(18, 1, 0, 0, 4'b0001, 0, 0);
        add(26, 1, 0, 0, 4'b0011, 0, 0);
        add(27, 0, 0, 0, 4'b0011, 0, 0);
        add(28, 0, 0, 0, 4'b0011, 0, 0);
        add(29, 0, 0, 0, 4'b0000, 0, 1);
        add(30, 0, 0, 1, 4'b0000, 0, 0);
        add(31, 0, 0, 0, 4'b0000, 0, 0);
        add(32, 1, 0, 0, 4'b0000, 0, 0);
        add(49, 1, 0, 0, 4'b0000, 0, 0);
        add(50, 1, 0, 0, 4'b0001, 0, 0);
        run_table("lock_loss", 50);

        // res_n pulsed between clock edges mid-RELEASE.
        do_reset();
        add(0,  1, 0, 0, 4'b0000, 0, 0);
        add(26, 1, 0, 0, 4'b0011, 0, 0);
        run_table("pre_async", 30);
        res_n = 1'b0;
        #1;
        check("async_reset", {ch_res_n, seq_done, lock_lost}, 6'b0);
        check("async_reset_n1", {3'b000, ch1_res_n, done1, lost1}, 6'b0);
        #4;
        res_n = 1'b1;
        // Full restart; a software request during RELEASE must be ignored.
        add(0,  1, 0, 0, 4'b0000, 0, 0);
        add(17, 1, 0, 0, 4'b0000, 0, 0);
        add(18, 1, 0, 0, 4'b0001, 0, 0);
        add(20, 1, 1, 0, 4'b0001, 0, 0);
        add(21, 1, 0, 0, 4'b0001, 0, 0);
        add(26, 1, 0, 0, 4'b0011, 0, 0);
        add(42, 1, 0, 0, 4'b1111, 1, 0);
        run_table("restart", 42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
